fixed_point_add: RTL and testbench

Registered, saturating signed fixed-point adder for two's-complement Qm.n operands (default Q2.14, 16-bit). Each clock it adds A_in and B_in, clamps the result to the representable range, and registers the sum with positive-saturation (overflow) and negative-saturation (underflow) flags. Used as a datapath arithmetic primitive wherever fixed-point values are accumulated or combined.

---
 rtl/fixed_point_add.sv | 68 ++++++
 tb/tb_fixed_point_add.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fixed_point_add.sv
// rtl/fixed_point_add.sv - registered saturating signed fixed-point adder
module fixed_point_add #(
  parameter int data_width = 16,
  parameter int frac_width = 14,
  parameter int int_width  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [data_width-1:0] A_in,
  input  logic signed [data_width-1:0] B_in,
  output logic signed [data_width-1:0] out,
  output logic                         overflow_flag,
  output logic                         underflow_flag
);

  // The Q format only fixes how the word is read; a mismatch is a configuration error.
  generate
    if (int_width + frac_width != data_width) begin : g_bad_format
      $error("fixed_point_add: int_width + frac_width must equal data_width");
    end
  endgenerate

  localparam logic [data_width-1:0] max_val = {1'b0, {(data_width-1){1'b1}}};
  localparam logic [data_width-1:0] min_val = {1'b1, {(data_width-1){1'b0}}};

  logic [data_width:0]   sum_ext;
  logic                  pos_sat;
  logic                  neg_sat;
  logic [data_width-1:0] out_d,  out_q;
  logic                  ovf_d,  ovf_q;
  logic                  unf_d,  unf_q;

  // One extra bit of headroom makes the true sum exact; the top two bits then
  // disagree only when the result left the representable range.
  always_comb begin
    sum_ext = {A_in[data_width-1], A_in} + {B_in[data_width-1], B_in};
    pos_sat = (sum_ext[data_width:data_width-1] == 2'b01);
    neg_sat = (sum_ext[data_width:data_width-1] == 2'b10);
    out_d   = sum_ext[data_width-1:0];
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (pos_sat) begin
      out_d = max_val;
      ovf_d = 1'b1;
    end else if (neg_sat) begin
      out_d = min_val;
      unf_d = 1'b1;
    end
  end

  // Register the clamped sum and flags; reset wins over the addition.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign out            = out_q;
  assign overflow_flag  = ovf_q;
  assign underflow_flag = unf_q;

endmodule

// File: tb/tb_fixed_point_add.sv
// tb/tb_fixed_point_add.sv - self-checking bench for fixed_point_add
module tb_fixed_point_add;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [15:0] out;
  logic        overflow_flag;
  logic        underflow_flag;

  int tests  = 0;
  int failed = 0;

  fixed_point_add #(.data_width(16), .frac_width(14), .int_width(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .A_in           (a_in),
    .B_in           (b_in),
    .out            (out),
    .overflow_flag  (overflow_flag),
    .underflow_flag (underflow_flag)
  );

  always #5 clk = ~clk;

  // Reference: exact integer sum clamped to [-32768, 32767].
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] o, output logic ov, output logic un);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sa + sb;
    ov = 1'b0;
    un = 1'b0;
    if (s > 32767) begin
      o  = 16'h7FFF;
      ov = 1'b1;
    end else if (s < -32768) begin
      o  = 16'h8000;
      un = 1'b1;
    end else begin
      o = s[15:0];
    end
  endfunction

  task automatic check(input string tag, input logic [15:0] eo, input logic eov, input logic eun);
    tests++;
    assert (out === eo) else begin
      failed++;
      $error("FAIL %s out got=%h exp=%h", tag, out, eo);
    end
    tests++;
    assert (overflow_flag === eov) else begin
      failed++;
      $error("FAIL %s overflow_flag got=%b exp=%b", tag, overflow_flag, eov);
    end
    tests++;
    assert (underflow_flag === eun) else begin
      failed++;
      $error("FAIL %s underflow_flag got=%b exp=%b", tag, underflow_flag, eun);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] eo;
    logic        eov, eun;
    @(negedge clk);
    a_in = a;
    b_in = b;
    model(a, b, eo, eov, eun);
    @(posedge clk);
    #1;
    check(tag, eo, eov, eun);
  endtask

  // Pick edge-heavy operands so saturation and exact boundaries are hit often.
  function automatic logic [15:0] pick();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0:       v = 16'h7FFF - 16'($urandom_range(0, 3));
      1:       v = 16'h8000 + 16'($urandom_range(0, 3));
      2:       v = 16'($urandom_range(0, 7)) - 16'd4;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    a_in  = 16'h7FFF;
    b_in  = 16'h0001;

    // Reset held across two edges with saturating inputs present.
    @(posedge clk); #1;
    check("reset_edge1", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("reset_edge2", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_release", 16'h7FFF, 1'b1, 1'b0);

    // Normal adds.
    step("norm_c_3",      16'h000C, 16'h0003);
    check("norm_c_3_lit", 16'h000F, 1'b0, 1'b0);
    step("norm_18_c",     16'h0018, 16'h000C);
    check("norm_18_c_lit", 16'h0024, 1'b0, 1'b0);
    step("norm_m1_p1",    16'hFFFF, 16'h0001);
    step("norm_mix_zero", 16'h8001, 16'h7FFF);
    step("norm_2_m2",     16'h0002, 16'hFFFE);
    step("norm_m1_m1",    16'hFFFF, 16'hFFFF);
    check("norm_m1_m1_lit", 16'hFFFE, 1'b0, 1'b0);

    // Positive saturation.
    step("pos_max_1",     16'h7FFF, 16'h0001);
    step("pos_max_max",   16'h7FFF, 16'h7FFF);
    step("pos_7ffc_4",    16'h7FFC, 16'h0004);
    check("pos_7ffc_4_lit", 16'h7FFF, 1'b1, 1'b0);

    // Negative saturation.
    step("neg_8001_8001", 16'h8001, 16'h8001);
    step("neg_min_min",   16'h8000, 16'h8000);
    check("neg_min_min_lit", 16'h8000, 1'b0, 1'b1);
    step("neg_8003_8003", 16'h8003, 16'h8003);
    step("neg_8001_c000", 16'h8001, 16'hC000);

    // Exact boundaries: no flag.
    step("exact_7ffc_3",  16'h7FFC, 16'h0003);
    check("exact_7ffc_3_lit", 16'h7FFF, 1'b0, 1'b0);
    step("exact_7ffe_1",  16'h7FFE, 16'h0001);
    step("exact_c000x2",  16'hC000, 16'hC000);
    check("exact_c000x2_lit", 16'h8000, 1'b0, 1'b0);
    step("exact_min_1",   16'h8000, 16'h0001);

    // Back-to-back alternation; flags must clear the cycle after saturation.
    for (int i = 0; i < 4; i++) begin
      step("b2b_ovf",  16'h7FF0, 16'h0100);
      step("b2b_norm", 16'h0010, 16'h0020);
      step("b2b_unf",  16'h8010, 16'hFF00);
      step("b2b_norm2", 16'hFFF0, 16'h0005);
    end

    // Mid-stream reset discards the in-flight sample.
    @(negedge clk);
    a_in  = 16'h7FFF;
    b_in  = 16'h7FFF;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("after_mid_reset", 16'h7FFF, 1'b1, 1'b0);

    // Outputs hold between edges.
    @(negedge clk);
    a_in = 16'h0001;
    b_in = 16'h0001;
    #2;
    check("hold_between_edges", 16'h7FFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("hold_next_edge", 16'h0002, 1'b0, 1'b0);

    // Randomized against the reference model.
    for (int i = 0; i < 300; i++) begin
      step("rand", pick(), pick());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
